systolic_mac_pe: RTL and testbench
==================================

Name: systolic_mac_pe

Overview:
Second-generation systolic-array processing element: a two-stage pipelined multiply-accumulate cell with A/B operand forwarding to its neighbours.
- Adds to the previous PE: signed/unsigned mode, optional saturation, tile framing via a last flag with automatic accumulator restart, and a valid/ready result buffer.
- One instance per array cell; the result port feeds the array's column drain logic.

Parameters:
DATA_WIDTH, 16, operand width of A and B
ACCUM_WIDTH, 40, accumulator and result width; must be >= 2*DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
pe_enable  input  1  global advance; 0 freezes the operand pipeline
in_valid  input  1  data_in_a/data_in_b carry a beat
in_last  input  1  beat is the final beat of a tile; qualified by in_valid
mode_signed  input  1  1 = two's-complement operands, 0 = unsigned
sat_en  input  1  1 = saturate the accumulator, 0 = wrap
data_in_a  input  DATA_WIDTH  operand A (from west)
data_in_b  input  DATA_WIDTH  operand B (from north)
data_out_a  output  DATA_WIDTH  registered A to east
data_out_b  output  DATA_WIDTH  registered B to south
out_valid  output  1  registered in_valid to neighbours
out_last  output  1  registered in_last to neighbours
accum_out  output  ACCUM_WIDTH  running accumulator (debug/legacy)
result_data  output  ACCUM_WIDTH  completed tile sum
result_valid  output  1  result_data holds an unconsumed tile sum
result_ready  input  1  consumer accepts result when result_valid is 1
ovf_flag  output  1  sticky: overflow or saturation occurred in the tile now held in result_data
overrun  output  1  sticky: a tile completed while the result buffer was full

Behaviour:
- All state updates on rising clk. When reset is 0 at an edge, every register and output clears to 0, including overrun. The first_beat internal flag sets to 1.
- Reset applied mid-tile discards the partial sum and any buffered result.
- Stage 1 (edge where pe_enable=1), registers:
  - data_out_a/b <= data_in_a/b
  - out_valid <= in_valid
  - out_last <= in_valid & in_last
  - prod <= A*B, 2*DATA_WIDTH wide, with signedness per mode
  - p_valid, p_last
  - p_mode and p_sat: sampled from mode_signed/sat_en on the first beat of a tile, then held until that tile's last beat.
- Stage 2 (edge where pe_enable=1 and p_valid=1):
  - base = first_beat ? 0 : accum.
  - sum = base + extended prod, computed in ACCUM_WIDTH+1 bits. Extension is sign or zero per p_mode.
  - Overflow means the result is not representable in ACCUM_WIDTH:
    - signed: operands same sign, result sign differs
    - unsigned: carry out of bit ACCUM_WIDTH-1
  - On overflow with p_sat=1: clamp. Signed clamps to +2^(ACCUM_WIDTH-1)-1 or -2^(ACCUM_WIDTH-1); unsigned clamps to 2^ACCUM_WIDTH-1. With p_sat=0: keep the low ACCUM_WIDTH bits.
  - Overflow in either case sets the tile overflow bit. That bit clears at tile start.
  - accum <= sum; first_beat <= p_last.
- pe_enable=0: stage 1, stage 2, accum and forwarding registers hold; in_valid is ignored. The result handshake still operates.
- Result capture, on the stage-2 edge processing a p_last beat:
  - If the buffer is free, or result_ready=1 that same cycle: result_data <= final sum, ovf_flag <= tile overflow bit, result_valid <= 1.
  - If the buffer is full and result_ready=0: the new result is dropped, the old result is kept and overrun sets.
- Handshake: a transfer completes on any edge with result_valid=1 and result_ready=1. Without a simultaneous capture, result_valid clears; ovf_flag is held until the next capture. result_data is stable while result_valid=1 and not accepted.
- Latency:
  - Forwarded operands appear 1 enabled edge after input.
  - A last beat presented at edge N produces result_valid=1 after edge N+1 (2 enabled edges from the input beat).
  - Back-to-back tiles with no idle beats are supported at full rate.
- A single-beat tile (in_valid=1 and in_last=1 with first_beat=1) yields result = A*B.
- accum_out shows the register value, including its value after a tile ends, until the next beat overwrites it.

Test Plan:
- Reset 0 for 2 edges mid-tile -> all outputs 0, result_valid 0. Next tile 2*3 + 4*5 (last on beat 2) -> result_data=26.
- Signed mode, beats (-3)*7, 2*(-4), (-1)*(-1) last -> result_data = -28 sign-extended to 40 bits, result_valid 2 edges after the last beat, ovf_flag 0.
- Unsigned mode, 0xFFFF*0xFFFF -> prod 0xFFFE0001, not negative. Signed mode, same bits -> +1.
- ACCUM_WIDTH=32, signed, sat_en=1, beats 0x7FFF*0x7FFF repeated 3 times -> result 0x7FFFFFFF, ovf_flag 1. Same run with sat_en=0 -> wrapped value, ovf_flag 1.
- Hold result_ready=0, complete two tiles -> first result kept, overrun 1. Raise result_ready -> one transfer, result_valid falls next edge.
- Toggle pe_enable=0 for 3 cycles mid-tile -> forwarding and accum frozen, in_valid beats ignored, final sum unchanged versus an uninterrupted run. Results stream back-to-back with result_ready=1 -> one result per tile.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Systolic-array processing element: two-stage pipelined MAC with A/B forwarding,
// signed/unsigned and saturating accumulation, tile framing and a one-entry result buffer.
module systolic_mac_pe #(
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 40
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pe_enable,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   mode_signed,
   input  logic                   sat_en,
   input  logic [DATA_WIDTH-1:0]  data_in_a,
   input  logic [DATA_WIDTH-1:0]  data_in_b,
   output logic [DATA_WIDTH-1:0]  data_out_a,
   output logic [DATA_WIDTH-1:0]  data_out_b,
   output logic                   out_valid,
   output logic                   out_last,
   output logic [ACCUM_WIDTH-1:0] accum_out,
   output logic [ACCUM_WIDTH-1:0] result_data,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   ovf_flag,
   output logic                   overrun
);

   localparam int DW  = DATA_WIDTH;
   localparam int AW  = ACCUM_WIDTH;
   localparam int PW  = 2 * DATA_WIDTH;
   localparam int EXT = ACCUM_WIDTH + 1 - PW;

   // ---------------- stage 1: operand capture and multiply ----------------
   logic [DW-1:0] a_q, b_q;
   logic          vld_q, lst_q;
   logic [PW-1:0] prod_q, prod_d;
   logic          p_mode_q, p_sat_q;
   logic          s1_first_q;
   logic          s1_mode, s1_sat;
   logic [PW-1:0] a_ext, b_ext;

   // Mode and saturation are latched on a tile's first beat and held for the rest of it.
   always_comb begin
      s1_mode = s1_first_q ? mode_signed : p_mode_q;
      s1_sat  = s1_first_q ? sat_en      : p_sat_q;
      a_ext   = {{DW{s1_mode & data_in_a[DW-1]}}, data_in_a};
      b_ext   = {{DW{s1_mode & data_in_b[DW-1]}}, data_in_b};
      prod_d  = a_ext * b_ext;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q        <= '0;
         b_q        <= '0;
         vld_q      <= 1'b0;
         lst_q      <= 1'b0;
         prod_q     <= '0;
         p_mode_q   <= 1'b0;
         p_sat_q    <= 1'b0;
         s1_first_q <= 1'b1;
      end else if (pe_enable) begin
         a_q    <= data_in_a;
         b_q    <= data_in_b;
         vld_q  <= in_valid;
         lst_q  <= in_valid & in_last;
         prod_q <= prod_d;
         if (in_valid) begin
            p_mode_q   <= s1_mode;
            p_sat_q    <= s1_sat;
            s1_first_q <= in_last;
         end
      end
   end

   // ---------------- stage 2: accumulate with overflow handling ----------------
   logic [AW-1:0] accum_q, accum_d;
   logic          first_q;
   logic          tovf_q, tovf_d;
   logic [AW-1:0] base;
   logic [AW:0]   base_ext, prod_ext, sum_w;
   logic          ovf;
   logic          fire2, cap, can_cap;

   always_comb begin
      base     = first_q ? '0 : accum_q;
      base_ext = {p_mode_q & base[AW-1], base};
      prod_ext = {{EXT{p_mode_q & prod_q[PW-1]}}, prod_q};
      sum_w    = base_ext + prod_ext;
      ovf      = 1'b0;
      accum_d  = sum_w[AW-1:0];
      if (p_mode_q) begin
         ovf = (base[AW-1] == prod_ext[AW-1]) && (sum_w[AW-1] != base[AW-1]);
         if (ovf && p_sat_q)
            accum_d = base[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
         ovf = sum_w[AW];
         if (ovf && p_sat_q)
            accum_d = '1;
      end
      tovf_d  = (first_q ? 1'b0 : tovf_q) | ovf;
      fire2   = pe_enable & vld_q;
      cap     = fire2 & lst_q;
      can_cap = ~result_valid | result_ready;
   end

   // ---------------- accumulator and result buffer ----------------
   logic [AW-1:0] rd_q;
   logic          rv_q, rovf_q, overrun_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         accum_q   <= '0;
         first_q   <= 1'b1;
         tovf_q    <= 1'b0;
         rd_q      <= '0;
         rv_q      <= 1'b0;
         rovf_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (fire2) begin
            accum_q <= accum_d;
            first_q <= lst_q;
            tovf_q  <= tovf_d;
         end
         if (cap && can_cap) begin
            rd_q   <= accum_d;
            rovf_q <= tovf_d;
            rv_q   <= 1'b1;
         end else begin
            if (cap)
               overrun_q <= 1'b1;
            if (rv_q && result_ready)
               rv_q <= 1'b0;
         end
      end
   end

   assign data_out_a   = a_q;
   assign data_out_b   = b_q;
   assign out_valid    = vld_q;
   assign out_last     = lst_q;
   assign accum_out    = accum_q;
   assign result_data  = rd_q;
   assign result_valid = rv_q;
   assign ovf_flag     = rovf_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: a 40-bit default instance plus a 32-bit
// accumulator instance sharing the same stimulus for the saturation cases.
module tb_systolic_mac_pe;

   logic        clk = 1'b0;
   logic        reset, pe_enable, in_valid, in_last, mode_signed, sat_en, result_ready;
   logic [15:0] data_in_a, data_in_b;

   logic [15:0] doa, dob, doa32, dob32;
   logic        ov, ol, rv, ovf, ovr, ov32, ol32, rv32, ovf32, ovr32;
   logic [39:0] acc, rd;
   logic [31:0] acc32, rd32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   systolic_mac_pe #(.DATA_WIDTH(16), .ACCUM_WIDTH(40)) dut (
      .clk(clk), .reset(reset), .pe_enable(pe_enable), .in_valid(in_valid),
      .in_last(in_last), .mode_signed(mode_signed), .sat_en(sat_en),
      .data_in_a(data_in_a), .data_in_b(data_in_b),
      .data_out_a(doa), .data_out_b(dob), .out_valid(ov), .out_last(ol),
      .accum_out(acc), .result_data(rd), .result_valid(rv),
      .result_ready(result_ready), .ovf_flag(ovf), .overrun(ovr)
   );

   systolic_mac_pe #(.DATA_WIDTH(16), .ACCUM_WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .pe_enable(pe_enable), .in_valid(in_valid),
      .in_last(in_last), .mode_signed(mode_signed), .sat_en(sat_en),
      .data_in_a(data_in_a), .data_in_b(data_in_b),
      .data_out_a(doa32), .data_out_b(dob32), .out_valid(ov32), .out_last(ol32),
      .accum_out(acc32), .result_data(rd32), .result_valid(rv32),
      .result_ready(result_ready), .ovf_flag(ovf32), .overrun(ovr32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic v, input logic l);
      data_in_a = a;
      data_in_b = b;
      in_valid  = v;
      in_last   = l;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b0; pe_enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      mode_signed = 1'b0; sat_en = 1'b0; result_ready = 1'b0;
      data_in_a = '0; data_in_b = '0;
      tick(); tick();
      reset = 1'b1;

      // Reset in the middle of a tile
      beat(16'd9, 16'd9, 1'b1, 1'b0);
      beat(16'd9, 16'd9, 1'b1, 1'b0);
      reset = 1'b0;
      tick(); tick();
      chk("rst_doa", 64'(doa), 64'd0);
      chk("rst_dob", 64'(dob), 64'd0);
      chk("rst_ov",  64'(ov), 64'd0);
      chk("rst_ol",  64'(ol), 64'd0);
      chk("rst_acc", 64'(acc), 64'd0);
      chk("rst_rd",  64'(rd), 64'd0);
      chk("rst_rv",  64'(rv), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_ovr", 64'(ovr), 64'd0);
      reset = 1'b1;

      // Unsigned 2*3 + 4*5
      beat(16'd2, 16'd3, 1'b1, 1'b0);
      chk("fwd_a1", 64'(doa), 64'd2);
      beat(16'd4, 16'd5, 1'b1, 1'b1);
      chk("fwd_a2", 64'(doa), 64'd4);
      chk("fwd_b2", 64'(dob), 64'd5);
      chk("fwd_last", 64'(ol), 64'd1);
      chk("t1_rv_early", 64'(rv), 64'd0);
      idle();
      chk("t1_rv", 64'(rv), 64'd1);
      chk("t1_rd", 64'(rd), 64'd26);
      chk("t1_acc", 64'(acc), 64'd26);
      result_ready = 1'b1;
      tick();
      chk("t1_drain", 64'(rv), 64'd0);
      chk("t1_acc_hold", 64'(acc), 64'd26);
      result_ready = 1'b0;

      // Signed (-3)*7 + 2*(-4) + (-1)*(-1) = -28
      mode_signed = 1'b1;
      beat(16'hFFFD, 16'd7, 1'b1, 1'b0);
      beat(16'd2, 16'hFFFC, 1'b1, 1'b0);
      beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      chk("s_rv_early", 64'(rv), 64'd0);
      idle();
      chk("s_rv", 64'(rv), 64'd1);
      chk("s_rd", 64'(rd), 64'h0000_00FF_FFFF_FFE4);
      chk("s_ovf", 64'(ovf), 64'd0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      // Mode is held for the whole tile: (-1)*2 then 0xFFFF*1 still signed -> -3
      beat(16'hFFFF, 16'd2, 1'b1, 1'b0);
      mode_signed = 1'b0;
      beat(16'hFFFF, 16'd1, 1'b1, 1'b1);
      idle();
      chk("hold_rd", 64'(rd), 64'h0000_00FF_FFFF_FFFD);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      // 0xFFFF*0xFFFF unsigned then signed, second captured while first is accepted
      mode_signed = 1'b0;
      beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      mode_signed = 1'b1;
      beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      chk("u_rd", 64'(rd), 64'h0000_0000_FFFE_0001);
      chk("u_rv", 64'(rv), 64'd1);
      result_ready = 1'b1;
      idle();
      chk("sx_rd", 64'(rd), 64'd1);
      chk("sx_rv", 64'(rv), 64'd1);
      idle();
      chk("sx_drain", 64'(rv), 64'd0);
      result_ready = 1'b0;

      // 0x7FFF^2 three times, signed saturating
      mode_signed = 1'b1; sat_en = 1'b1;
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
      idle();
      chk("sat32_rd", 64'(rd32), 64'h7FFF_FFFF);
      chk("sat32_ovf", 64'(ovf32), 64'd1);
      chk("sat40_rd", 64'(rd), 64'h0000_0000_BFFD_0003);
      chk("sat40_ovf", 64'(ovf), 64'd0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      sat_en = 1'b0;
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
      idle();
      chk("wrap32_rd", 64'(rd32), 64'hBFFD_0003);
      chk("wrap32_ovf", 64'(ovf32), 64'd1);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      mode_signed = 1'b0;

      // Buffer full: second tile dropped, overrun sticky
      beat(16'd1, 16'd1, 1'b1, 1'b1);
      beat(16'd2, 16'd2, 1'b1, 1'b1);
      idle();
      chk("ovr_rd", 64'(rd), 64'd1);
      chk("ovr_rv", 64'(rv), 64'd1);
      chk("ovr_flag", 64'(ovr), 64'd1);
      chk("ovf32_clear", 64'(ovf32), 64'd0);
      result_ready = 1'b1;
      tick();
      chk("ovr_drain", 64'(rv), 64'd0);
      chk("ovr_sticky", 64'(ovr), 64'd1);
      result_ready = 1'b0;

      // Freeze mid-tile: 3*5 + 6*7 + 2*2 = 61
      beat(16'd3, 16'd5, 1'b1, 1'b0);
      beat(16'd6, 16'd7, 1'b1, 1'b0);
      pe_enable = 1'b0;
      beat(16'd100, 16'd100, 1'b1, 1'b1);
      beat(16'd100, 16'd100, 1'b1, 1'b1);
      beat(16'd100, 16'd100, 1'b1, 1'b1);
      chk("frz_doa", 64'(doa), 64'd6);
      chk("frz_acc", 64'(acc), 64'd15);
      chk("frz_rv", 64'(rv), 64'd0);
      pe_enable = 1'b1;
      beat(16'd2, 16'd2, 1'b1, 1'b1);
      idle();
      chk("frz_rd", 64'(rd), 64'd61);
      chk("frz_rv2", 64'(rv), 64'd1);

      // Back-to-back tiles with ready held high: 14, 86, 4
      result_ready = 1'b1;
      beat(16'd1, 16'd2, 1'b1, 1'b0);
      beat(16'd3, 16'd4, 1'b1, 1'b1);
      beat(16'd5, 16'd6, 1'b1, 1'b0);
      chk("b2b_rd1", 64'(rd), 64'd14);
      chk("b2b_rv1", 64'(rv), 64'd1);
      beat(16'd7, 16'd8, 1'b1, 1'b1);
      chk("b2b_gap", 64'(rv), 64'd0);
      beat(16'd2, 16'd2, 1'b1, 1'b1);
      chk("b2b_rd2", 64'(rd), 64'd86);
      idle();
      chk("b2b_rd3", 64'(rd), 64'd4);
      chk("b2b_rv3", 64'(rv), 64'd1);
      idle();
      chk("b2b_end", 64'(rv), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
